// File: rtl/squid_gf16_pkg.sv
// ---------------------------------------------------------------------------
// squid_gf16_pkg
// Shared GF(16) arithmetic for the SQUID decoder Chien search.
//   gf16_t        : one field element
//   GF_POLY       : primitive polynomial x^4 + x + 1
//   ALPHA_POW     : alpha^e for e = 0..14 (alpha = 4'd2)
//   gf16_mul      : field multiply
//   chien_state_e : sequencing FSM states
// ---------------------------------------------------------------------------
package squid_gf16_pkg;

    typedef logic [3:0] gf16_t;

    localparam logic [4:0] GF_POLY = 5'b10011;

    localparam gf16_t ALPHA_POW [0:14] = '{
        4'd1,  4'd2,  4'd4,  4'd8,  4'd3,  4'd6,  4'd12, 4'd11,
        4'd5,  4'd10, 4'd7,  4'd14, 4'd15, 4'd13, 4'd9
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } chien_state_e;

    // Shift-and-add multiply; the multiplicand is reduced by the field
    // polynomial each time it is doubled.
    function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
        gf16_t r;
        gf16_t aa;
        r  = '0;
        aa = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) begin
                r = r ^ aa;
            end
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ GF_POLY[3:0]) : {aa[2:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/chien_eval_slice.sv
// ---------------------------------------------------------------------------
// chien_eval_slice
// Combinational test of one search position: l0 ^ t1*alpha^K ^ t2*alpha^(2K).
//   K       : slice offset from the current base position
//   i_l0    : constant coefficient
//   i_t1    : lambda1 term at the base position
//   i_t2    : lambda2 term at the base position
//   o_hit   : 1 when the polynomial evaluates to zero
// ---------------------------------------------------------------------------
module chien_eval_slice
    import squid_gf16_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  gf16_t i_l0,
    input  gf16_t i_t1,
    input  gf16_t i_t2,
    output logic  o_hit
);

    localparam gf16_t C1 = ALPHA_POW[K % 15];
    localparam gf16_t C2 = ALPHA_POW[(2 * K) % 15];

    gf16_t w_sum;

    always_comb begin
        w_sum = i_l0 ^ gf16_mul(i_t1, C1) ^ gf16_mul(i_t2, C2);
        o_hit = (w_sum == '0);
    end

endmodule

// File: rtl/chien_seq_ctrl.sv
// ---------------------------------------------------------------------------
// chien_seq_ctrl
// Sequencing controller for the GF(16) Chien root search of a degree-2
// error-locator polynomial. Positions 0..NUM_POS-1 (x = alpha^(i+1)) are
// tested PAR per cycle with incrementally stepped term registers.
// Optional build macro: CHIEN_EARLY_TERM_EN (stop as soon as all roots seen).
// Ports:
//   clk, rst                  : clock, async active-high reset
//   in_valid/in_ready         : lambda input handshake
//   in_lambda0/1/2            : locator coefficients (x^0, x^1, x^2)
//   out_valid/out_ready       : result handshake, result held until taken
//   out_locator               : bit i set when position i is a root
//   out_err_cnt               : roots found, saturating at 3
//   out_fail                  : root count differs from polynomial degree
//   busy                      : high during SEARCH and DONE
// ---------------------------------------------------------------------------
module chien_seq_ctrl
    import squid_gf16_pkg::*;
#(
    parameter int unsigned NUM_POS = 8,
    parameter int unsigned PAR     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_lambda0,
    input  logic [3:0]         in_lambda1,
    input  logic [3:0]         in_lambda2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_POS-1:0] out_locator,
    output logic [1:0]         out_err_cnt,
    output logic               out_fail,
    output logic               busy
);

    localparam int unsigned PW    = $clog2(NUM_POS + 1);
    localparam gf16_t       STEP1 = ALPHA_POW[PAR % 15];
    localparam gf16_t       STEP2 = ALPHA_POW[(2 * PAR) % 15];

    chien_state_e       r_state;
    gf16_t              r_l0;
    gf16_t              r_t1;
    gf16_t              r_t2;
    logic [1:0]         r_deg;
    logic               r_zero;
    logic [1:0]         r_cnt;
    logic [NUM_POS-1:0] r_loc;
    logic [PW-1:0]      r_pos;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_fail;
    logic               r_busy;

    logic [PAR-1:0]     w_hit;
    logic [PAR-1:0]     w_hit_m;
    logic [3:0]         w_sum;
    logic [3:0]         w_tot;
    logic [1:0]         w_cnt_next;
    logic [NUM_POS-1:0] w_loc_next;
    logic [PW-1:0]      w_pos_next;
    logic               w_last;
    logic               w_early;
    logic               w_accept;

    for (genvar k = 0; k < PAR; k++) begin : g_slice
        chien_eval_slice #(.K(k)) u_slice (
            .i_l0  (r_l0),
            .i_t1  (r_t1),
            .i_t2  (r_t2),
            .o_hit (w_hit[k])
        );
    end

    always_comb begin
        // An all-zero polynomial "hits" everywhere; it means no error.
        w_hit_m = r_zero ? '0 : w_hit;
        w_sum   = '0;
        for (int unsigned k = 0; k < PAR; k++) begin
            w_sum = w_sum + {3'b000, w_hit_m[k]};
        end
        w_tot      = {2'b00, r_cnt} + w_sum;
        w_cnt_next = (w_tot > 4'd3) ? 2'd3 : w_tot[1:0];
        w_loc_next = r_loc | (NUM_POS'(w_hit_m) << r_pos);
        w_pos_next = r_pos + PW'(PAR);
        w_last     = (w_pos_next == PW'(NUM_POS));
        w_accept   = in_valid && r_in_ready;
    end

`ifdef CHIEN_EARLY_TERM_EN
    // Uses the count including this cycle's hits, so DONE follows the
    // edge on which the last root is recorded.
    assign w_early = (r_deg == 2'd0) || (w_cnt_next == r_deg);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_l0        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_deg       <= '0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
            r_loc       <= '0;
            r_pos       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_l0       <= in_lambda0;
                        r_t1       <= gf16_mul(in_lambda1, ALPHA_POW[1]);
                        r_t2       <= gf16_mul(in_lambda2, ALPHA_POW[2]);
                        r_deg      <= (in_lambda2 != '0) ? 2'd2 :
                                      (in_lambda1 != '0) ? 2'd1 : 2'd0;
                        r_zero     <= (in_lambda0 == '0) && (in_lambda1 == '0) &&
                                      (in_lambda2 == '0);
                        r_cnt      <= '0;
                        r_loc      <= '0;
                        r_pos      <= '0;
                        r_fail     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    r_loc <= w_loc_next;
                    r_cnt <= w_cnt_next;
                    r_t1  <= gf16_mul(r_t1, STEP1);
                    r_t2  <= gf16_mul(r_t2, STEP2);
                    r_pos <= w_pos_next;
                    if (w_last || w_early) begin
                        r_fail      <= (w_cnt_next != r_deg);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_locator = r_loc;
    assign out_err_cnt = r_cnt;
    assign out_fail    = r_fail;
    assign busy        = r_busy;

endmodule

// File: tb/tb_chien_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chien_seq_ctrl
// Scoreboard bench: two instances (PAR=1 and PAR=4) share the input stream.
// Expected results come from direct polynomial evaluation in the bench.
// ---------------------------------------------------------------------------
module tb_chien_seq_ctrl;

    localparam int NP = 8;

    typedef struct {
        logic [7:0] loc;
        logic [1:0] cnt;
        logic       fail;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] l0 = '0, l1 = '0, l2 = '0;
    logic       out_ready = 1'b0;

    logic       ir1, ov1, fail1, busy1;
    logic [7:0] loc1;
    logic [1:0] cnt1;
    logic       ir4, ov4, fail4, busy4;
    logic [7:0] loc4;
    logic [1:0] cnt4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   manual = 1'b0;
    bit   new1 = 1'b1;
    bit   new4 = 1'b1;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    chien_seq_ctrl #(.NUM_POS(NP), .PAR(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .in_lambda0(l0), .in_lambda1(l1), .in_lambda2(l2),
        .out_valid(ov1), .out_ready(out_ready), .out_locator(loc1),
        .out_err_cnt(cnt1), .out_fail(fail1), .busy(busy1)
    );

    chien_seq_ctrl #(.NUM_POS(NP), .PAR(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .in_lambda0(l0), .in_lambda1(l1), .in_lambda2(l2),
        .out_valid(ov4), .out_ready(out_ready), .out_locator(loc4),
        .out_err_cnt(cnt4), .out_fail(fail4), .busy(busy4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Carry-less product, then reduce bits 6..4 by x^4 = x + 1.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ (7'(a) << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ (7'(5'b10011) << (i - 4));
        end
        return p[3:0];
    endfunction

    function automatic logic [3:0] apow(input int e);
        logic [3:0] x;
        x = 4'd1;
        for (int i = 0; i < e; i++) x = gmul(x, 4'd2);
        return x;
    endfunction

    function automatic exp_t model(input logic [3:0] a0, input logic [3:0] a1,
                                   input logic [3:0] a2, input int par);
        exp_t       e;
        int         deg;
        int         cnt;
        int         cycles;
        bit         zero;
        bit         stop;
        int         pos;
        logic [3:0] x;
        e.loc  = '0;
        e.acc  = 0;
        cnt    = 0;
        cycles = 0;
        stop   = 1'b0;
        deg    = (a2 != 0) ? 2 : (a1 != 0) ? 1 : 0;
        zero   = (a0 == 0) && (a1 == 0) && (a2 == 0);
        for (int c = 0; c < NP / par; c++) begin
            if (!stop) begin
                cycles++;
                for (int k = 0; k < par; k++) begin
                    pos = c * par + k;
                    x   = apow(pos + 1);
                    if (!zero && ((a0 ^ gmul(a1, x) ^ gmul(a2, gmul(x, x))) == 4'd0)) begin
                        e.loc[pos] = 1'b1;
                        if (cnt < 3) cnt++;
                    end
                end
`ifdef CHIEN_EARLY_TERM_EN
                if (deg == 0 || cnt == deg) stop = 1'b1;
`endif
            end
        end
        e.cnt  = 2'(cnt);
        e.fail = (cnt != deg);
        e.lat  = cycles + 1;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compares every cycle a result is presented, so a held result
    // must stay equal to its expectation until it is taken.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ov1) begin
                    if (q1.size() == 0) chk("p1_spurious_valid", 1, 0);
                    else begin
                        if (new1) begin
                            chk("p1_latency", cyc - q1[0].acc, q1[0].lat);
                            new1 = 1'b0;
                        end
                        chk("p1_locator", int'(loc1), int'(q1[0].loc));
                        chk("p1_err_cnt", int'(cnt1), int'(q1[0].cnt));
                        chk("p1_fail", int'(fail1), int'(q1[0].fail));
                        chk("p1_in_ready_done", int'(ir1), 0);
                        chk("p1_busy_done", int'(busy1), 1);
                        if (out_ready) begin
                            void'(q1.pop_front());
                            new1 = 1'b1;
                        end
                    end
                end
                if (ov4) begin
                    if (q4.size() == 0) chk("p4_spurious_valid", 1, 0);
                    else begin
                        if (new4) begin
                            chk("p4_latency", cyc - q4[0].acc, q4[0].lat);
                            new4 = 1'b0;
                        end
                        chk("p4_locator", int'(loc4), int'(q4[0].loc));
                        chk("p4_err_cnt", int'(cnt4), int'(q4[0].cnt));
                        chk("p4_fail", int'(fail4), int'(q4[0].fail));
                        chk("p4_in_ready_done", int'(ir4), 0);
                        if (out_ready) begin
                            void'(q4.pop_front());
                            new4 = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!manual) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
        exp_t e;
        int   n;
        n = 0;
        while (!(ir1 && ir4) && n < 100) begin
            tick();
            n++;
        end
        if (!(ir1 && ir4)) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            l0 = a0;
            l1 = a1;
            l2 = a2;
            in_valid = 1'b1;
            e = model(a0, a1, a2, 1);
            e.acc = cyc;
            q1.push_back(e);
            e = model(a0, a1, a2, 4);
            e.acc = cyc;
            q4.push_back(e);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_pending", q1.size() + q4.size(), 0);
    endtask

    task automatic issue_two_roots();
        logic [3:0] r1, r2;
        r1 = apow($urandom_range(1, 15));
        r2 = apow($urandom_range(1, 15));
        issue(4'd1, r1 ^ r2, gmul(r1, r2));
    endtask

    initial begin
        logic [11:0] dir [5];
        dir[0] = {4'd0, 4'd1, 4'd3};
        dir[1] = {4'd1, 4'd6, 4'd8};
        dir[2] = {4'd0, 4'd1, 4'd10};
        dir[3] = {4'd0, 4'd0, 4'd0};
        dir[4] = {4'd0, 4'd0, 4'd5};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready1", int'(ir1), 0);
        chk("rst_in_ready4", int'(ir4), 0);
        chk("rst_out_valid", int'(ov1), 0);
        chk("rst_locator", int'(loc1), 0);
        chk("rst_err_cnt", int'(cnt1), 0);
        chk("rst_fail", int'(fail1), 0);
        chk("rst_busy", int'(busy1), 0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            issue(dir[i][11:8], dir[i][7:4], dir[i][3:0]);
            drain();
        end

        // Randomised coefficients and constructed two-root polynomials
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) issue(4'($urandom), 4'($urandom), 4'($urandom));
            else issue_two_roots();
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Held result: stable outputs, in_ready low, stray in_valid ignored
        manual = 1'b1;
        out_ready = 1'b0;
        issue(4'd1, 4'd6, 4'd8);
        for (int n = 0; n < 100 && !ov1; n++) tick();
        chk("hold_reached_done", int'(ov1), 1);
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            l0 = 4'($urandom);
            l1 = 4'($urandom);
            l2 = 4'($urandom);
            tick();
            chk("hold_in_ready1", int'(ir1), 0);
            chk("hold_in_ready4", int'(ir4), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("accept_ov_low", int'(ov1), 0);
        chk("accept_in_ready_high", int'(ir1), 1);
        chk("accept_busy_low", int'(busy1), 0);
        manual = 1'b0;
        repeat (20) tick();
        chk("stray_not_accepted", q1.size() + q4.size(), 0);

        // Reset during search discards the partial result
        issue_two_roots();
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(ov1), 0);
        chk("midrst_busy", int'(busy1), 0);
        chk("midrst_in_ready", int'(ir1), 0);
        chk("midrst_locator", int'(loc1), 0);
        chk("midrst_err_cnt", int'(cnt1), 0);
        q1.delete();
        q4.delete();
        new1 = 1'b1;
        new4 = 1'b1;
        tick();
        rst = 1'b0;
        issue(4'd0, 4'd1, 4'd3);
        drain();
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
